// File: rtl/sdram_arb_pkg.sv
// Shared constants for the 68k/SPI SDRAM port arbiter: FSM encodings,
// grant sources and the timeout read pattern.
package sdram_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CPU_ACC = 3'd1;
  localparam logic [2:0] ST_CPU_END = 3'd2;
  localparam logic [2:0] ST_SPI_ACC = 3'd3;
  localparam logic [2:0] ST_SPI_END = 3'd4;

  localparam logic [15:0] SPI_TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_SPI  = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/sdram_arb_68k_if.sv
// SDRAM controller port as seen by the arbiter (master) and by
// sdram_pnru_68k (slave). Strobes are active low, mem_ack is a 1-cycle pulse.
interface sdram_arb_68k_if #(
  parameter int ADDR_W = 23
) ();
  logic              mem_asn;
  logic              mem_udsn;
  logic              mem_ldsn;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [15:0]       mem_dout;
  logic              mem_ack;

  modport master (
    output mem_asn, mem_udsn, mem_ldsn, mem_rw, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport slave (
    input  mem_asn, mem_udsn, mem_ldsn, mem_rw, mem_addr, mem_din,
    output mem_dout, mem_ack
  );
endinterface

// File: rtl/sdram_arb_prio.sv
// Starvation-limited priority: the CPU normally wins, but after STARVE_MAX
// CPU grants with SPI waiting, SPI is forced through.
module sdram_arb_prio #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_pend,
  input  logic spi_req,
  input  logic grant_taken,
  output logic gnt_cpu,
  output logic gnt_spi
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  always_comb begin
    starved      = (starve_cnt_q == CW'(STARVE_MAX));
    gnt_spi      = spi_req & (!cpu_pend | starved);
    gnt_cpu      = cpu_pend & !gnt_spi;
    starve_cnt_d = starve_cnt_q;
    // Only grants the FSM actually takes move the counter.
    if (grant_taken) begin
      if (gnt_spi)
        starve_cnt_d = '0;
      else if (gnt_cpu && spi_req && !starved)
        starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end
endmodule

// File: rtl/sdram_arb_68k.sv
// Sequenced arbiter for the single SDRAM controller port: 68k bus vs SPI loader,
// with DTACK generated from controller completion. Optional SDRAM_ARB_TIMEOUT_EN
// adds an ack watchdog that raises BERR (CPU) or returns 16'hDEAD (SPI).
module sdram_arb_68k
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int STARVE_MAX  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_excl,
  input  logic              cpu_as_n,
  input  logic              cpu_sel,
  input  logic              cpu_rw,
  input  logic              cpu_uds_n,
  input  logic              cpu_lds_n,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [15:0]       cpu_dout,
  output logic [15:0]       cpu_din,
  output logic              cpu_dtack_n,
  output logic              cpu_berr_n,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [15:0]       spi_wdata,
  output logic [15:0]       spi_rdata,
  output logic              spi_ack,
  sdram_arb_68k_if.master   mem
);

  logic [2:0]        state_q, state_d;
  logic              mem_asn_q, mem_asn_d;
  logic              mem_udsn_q, mem_udsn_d;
  logic              mem_ldsn_q, mem_ldsn_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic [15:0]       cpu_din_q, cpu_din_d;
  logic              cpu_dtack_n_q, cpu_dtack_n_d;
  logic [15:0]       spi_rdata_q, spi_rdata_d;
  logic              spi_ack_q, spi_ack_d;

  logic              cpu_pend, gnt_cpu, gnt_spi;
  gnt_src_e          gnt_src;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  logic          cpu_berr_n_q, cpu_berr_n_d;
`endif

  assign cpu_pend = !cpu_as_n & cpu_sel & !spi_excl;

  sdram_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_pend    (cpu_pend),
    .spi_req     (spi_req),
    .grant_taken (state_q == ST_IDLE),
    .gnt_cpu     (gnt_cpu),
    .gnt_spi     (gnt_spi)
  );

  always_comb begin
    state_d       = state_q;
    mem_asn_d     = mem_asn_q;
    mem_udsn_d    = mem_udsn_q;
    mem_ldsn_d    = mem_ldsn_q;
    mem_rw_d      = mem_rw_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    cpu_din_d     = cpu_din_q;
    cpu_dtack_n_d = cpu_dtack_n_q;
    spi_rdata_d   = spi_rdata_q;
    spi_ack_d     = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    cpu_berr_n_d  = cpu_berr_n_q;
    tmo_cnt_d     = (state_q == ST_CPU_ACC || state_q == ST_SPI_ACC) ? tmo_cnt_q + 1'b1 : '0;
    tmo_hit       = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`endif

    gnt_src = GNT_NONE;
    if (state_q == ST_IDLE) begin
      if (gnt_spi)      gnt_src = GNT_SPI;
      else if (gnt_cpu) gnt_src = GNT_CPU;
    end

    case (state_q)
      ST_IDLE: begin
        case (gnt_src)
          GNT_SPI: begin
            mem_asn_d  = 1'b0;
            mem_udsn_d = 1'b0;
            mem_ldsn_d = 1'b0;
            mem_rw_d   = !spi_we;
            mem_addr_d = spi_addr;
            mem_din_d  = spi_wdata;
            state_d    = ST_SPI_ACC;
          end
          GNT_CPU: begin
            mem_asn_d  = 1'b0;
            mem_udsn_d = cpu_uds_n;
            mem_ldsn_d = cpu_lds_n;
            mem_rw_d   = cpu_rw;
            mem_addr_d = cpu_a;
            mem_din_d  = cpu_dout;
            state_d    = ST_CPU_ACC;
          end
          default: ;
        endcase
      end

      ST_CPU_ACC: begin
        if (mem.mem_ack) begin
          if (mem_rw_q) cpu_din_d = mem.mem_dout;
          mem_asn_d  = 1'b1;
          mem_udsn_d = 1'b1;
          mem_ldsn_d = 1'b1;
          mem_rw_d   = 1'b1;
          // An aborted bus cycle still finishes the access, just without DTACK.
          if (!cpu_as_n) cpu_dtack_n_d = 1'b0;
          state_d = ST_CPU_END;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          mem_asn_d  = 1'b1;
          mem_udsn_d = 1'b1;
          mem_ldsn_d = 1'b1;
          mem_rw_d   = 1'b1;
          if (!cpu_as_n) cpu_berr_n_d = 1'b0;
          state_d = ST_CPU_END;
        end
`endif
      end

      ST_CPU_END: begin
        if (cpu_as_n) begin
          cpu_dtack_n_d = 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
          cpu_berr_n_d  = 1'b1;
`endif
          state_d = ST_IDLE;
        end
      end

      ST_SPI_ACC: begin
        if (mem.mem_ack) begin
          if (mem_rw_q) spi_rdata_d = mem.mem_dout;
          spi_ack_d  = 1'b1;
          mem_asn_d  = 1'b1;
          mem_udsn_d = 1'b1;
          mem_ldsn_d = 1'b1;
          mem_rw_d   = 1'b1;
          state_d    = ST_SPI_END;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          spi_rdata_d = SPI_TIMEOUT_DATA;
          spi_ack_d   = 1'b1;
          mem_asn_d   = 1'b1;
          mem_udsn_d  = 1'b1;
          mem_ldsn_d  = 1'b1;
          mem_rw_d    = 1'b1;
          state_d     = ST_SPI_END;
        end
`endif
      end

      // Gap cycle keeps a still-high spi_req from being re-granted.
      ST_SPI_END: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mem_asn_q     <= 1'b1;
      mem_udsn_q    <= 1'b1;
      mem_ldsn_q    <= 1'b1;
      mem_rw_q      <= 1'b1;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      cpu_din_q     <= '0;
      cpu_dtack_n_q <= 1'b1;
      spi_rdata_q   <= '0;
      spi_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_asn_q     <= mem_asn_d;
      mem_udsn_q    <= mem_udsn_d;
      mem_ldsn_q    <= mem_ldsn_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      cpu_din_q     <= cpu_din_d;
      cpu_dtack_n_q <= cpu_dtack_n_d;
      spi_rdata_q   <= spi_rdata_d;
      spi_ack_q     <= spi_ack_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q    <= '0;
      cpu_berr_n_q <= 1'b1;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      cpu_berr_n_q <= cpu_berr_n_d;
    end
  end
  assign cpu_berr_n = cpu_berr_n_q;
`else
  assign cpu_berr_n = 1'b1;
`endif

  assign mem.mem_asn  = mem_asn_q;
  assign mem.mem_udsn = mem_udsn_q;
  assign mem.mem_ldsn = mem_ldsn_q;
  assign mem.mem_rw   = mem_rw_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;
  assign cpu_din      = cpu_din_q;
  assign cpu_dtack_n  = cpu_dtack_n_q;
  assign spi_rdata    = spi_rdata_q;
  assign spi_ack      = spi_ack_q;

endmodule

// File: tb/tb_sdram_arb_68k.sv
// Directed bench for sdram_arb_68k: simple SDRAM model acking a fixed delay
// after mem_asn falls, plus a negedge monitor recording strobe/ack history.
module tb_sdram_arb_68k;
  import sdram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_excl = 1'b0;
  logic        cpu_as_n = 1'b1, cpu_sel = 1'b0, cpu_rw = 1'b1;
  logic        cpu_uds_n = 1'b1, cpu_lds_n = 1'b1;
  logic [22:0] cpu_a = '0;
  logic [15:0] cpu_dout = '0;
  logic [15:0] cpu_din;
  logic        cpu_dtack_n, cpu_berr_n;
  logic        spi_req = 1'b0, spi_we = 1'b0;
  logic [22:0] spi_addr = '0;
  logic [15:0] spi_wdata = '0;
  logic [15:0] spi_rdata;
  logic        spi_ack;

  sdram_arb_68k_if #(.ADDR_W(23)) mem_if ();

  sdram_arb_68k dut (
    .clk(clk), .reset_n(reset_n), .spi_excl(spi_excl),
    .cpu_as_n(cpu_as_n), .cpu_sel(cpu_sel), .cpu_rw(cpu_rw),
    .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n(cpu_berr_n), .spi_req(spi_req), .spi_we(spi_we),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_ack(spi_ack), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // SDRAM model
  logic        ack_en = 1'b1;
  int          ack_dly = 3;
  logic [15:0] mem_rdata = 16'h0000;
  logic        inject_ack = 1'b0;
  int          wcnt = 0;
  logic        acked = 1'b0;

  always @(posedge clk) begin
    mem_if.mem_ack <= 1'b0;
    if (inject_ack) begin
      mem_if.mem_ack  <= 1'b1;
      mem_if.mem_dout <= mem_rdata;
    end else if (mem_if.mem_asn === 1'b0 && ack_en && !acked) begin
      if (wcnt == ack_dly - 1) begin
        mem_if.mem_ack  <= 1'b1;
        mem_if.mem_dout <= mem_rdata;
        acked           <= 1'b1;
      end else wcnt <= wcnt + 1;
    end
    if (mem_if.mem_asn !== 1'b0) begin
      wcnt  <= 0;
      acked <= 1'b0;
    end
  end

  // Monitor
  int          ncyc = 0, ack_n = -1, dtack_fall_n = -1, asn_fall_n = -1;
  int          asn_falls = 0, dtack_low_cnt = 0, spi_ack_cnt = 0;
  logic        dtack_prev = 1'b1, asn_prev = 1'b1;
  logic        cap_udsn, cap_ldsn, cap_rw;
  logic [22:0] cap_addr;
  logic [15:0] cap_din;

  always @(negedge clk) begin
    ncyc++;
    if (mem_if.mem_ack === 1'b1) ack_n = ncyc;
    if (dtack_prev === 1'b1 && cpu_dtack_n === 1'b0) dtack_fall_n = ncyc;
    if (asn_prev === 1'b1 && mem_if.mem_asn === 1'b0) begin
      asn_falls++;
      asn_fall_n = ncyc;
      cap_udsn   = mem_if.mem_udsn;
      cap_ldsn   = mem_if.mem_ldsn;
      cap_rw     = mem_if.mem_rw;
      cap_addr   = mem_if.mem_addr;
      cap_din    = mem_if.mem_din;
    end
    if (cpu_dtack_n === 1'b0) dtack_low_cnt++;
    if (spi_ack === 1'b1) spi_ack_cnt++;
    dtack_prev = cpu_dtack_n;
    asn_prev   = mem_if.mem_asn;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_dtack(input string nm);
    int n = 0;
    while (cpu_dtack_n !== 1'b0 && n < 400) begin tick(); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL %s: dtack timeout, dtack_n=%b required 0", nm, cpu_dtack_n); end
  endtask

  task automatic wait_spi_ack(input string nm);
    int n = 0;
    while (spi_ack !== 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL %s: spi_ack timeout, spi_ack=%b required 1", nm, spi_ack); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks += 9;
    if (mem_if.mem_asn !== 1'b1)  begin errors++; $display("FAIL rst_asn: got %b want 1", mem_if.mem_asn); end
    if (mem_if.mem_udsn !== 1'b1) begin errors++; $display("FAIL rst_udsn: got %b want 1", mem_if.mem_udsn); end
    if (mem_if.mem_ldsn !== 1'b1) begin errors++; $display("FAIL rst_ldsn: got %b want 1", mem_if.mem_ldsn); end
    if (mem_if.mem_rw !== 1'b1)   begin errors++; $display("FAIL rst_rw: got %b want 1", mem_if.mem_rw); end
    if (cpu_dtack_n !== 1'b1)     begin errors++; $display("FAIL rst_dtack: got %b want 1", cpu_dtack_n); end
    if (cpu_berr_n !== 1'b1)      begin errors++; $display("FAIL rst_berr: got %b want 1", cpu_berr_n); end
    if (spi_ack !== 1'b0)         begin errors++; $display("FAIL rst_spi_ack: got %b want 0", spi_ack); end
    if (cpu_din !== 16'h0 || spi_rdata !== 16'h0) begin errors++; $display("FAIL rst_data: cpu_din=%h spi_rdata=%h want 0", cpu_din, spi_rdata); end
    if (dut.state_q !== ST_IDLE || dut.u_prio.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL rst_state: state=%0d starve=%0d want 0/0", dut.state_q, dut.u_prio.starve_cnt_q); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    ack_en = 1'b1; ack_dly = 3; mem_rdata = 16'h4E71;
    cpu_a = 23'h000800; cpu_rw = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    cpu_sel = 1'b1; cpu_as_n = 1'b0;
    wait_dtack("rd_wait");
    tick(); tick();
    checks += 6;
    if (cpu_din !== 16'h4E71) begin errors++; $display("FAIL rd_data: got %h want 4e71", cpu_din); end
    if (dtack_fall_n - ack_n !== 1) begin errors++; $display("FAIL rd_dtack_lat: ack->dtack %0d want 1", dtack_fall_n - ack_n); end
    if (dtack_fall_n - asn_fall_n !== 4) begin errors++; $display("FAIL rd_total_lat: asn->dtack %0d want 4", dtack_fall_n - asn_fall_n); end
    if (cap_addr !== 23'h000800 || cap_rw !== 1'b1) begin errors++; $display("FAIL rd_addr: addr=%h rw=%b want 000800/1", cap_addr, cap_rw); end
    if (cpu_dtack_n !== 1'b0 || mem_if.mem_asn !== 1'b1) begin errors++; $display("FAIL rd_hold: dtack_n=%b asn=%b want 0/1", cpu_dtack_n, mem_if.mem_asn); end
    cpu_as_n = 1'b1;
    tick();
    if (cpu_dtack_n !== 1'b1 || dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rd_release: dtack_n=%b state=%0d want 1/0", cpu_dtack_n, dut.state_q); end
    cpu_sel = 1'b0;
    tick();
  endtask

  task automatic test_spi_write_excl();
    int f0 = asn_falls, d0 = dtack_low_cnt, s0 = spi_ack_cnt;
    ack_en = 1'b1;
    spi_excl = 1'b1;
    cpu_a = 23'h000100; cpu_rw = 1'b1; cpu_sel = 1'b1; cpu_as_n = 1'b0;
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 23'h10; spi_wdata = 16'hA55A;
    wait_spi_ack("spiw_wait");
    spi_req = 1'b0;
    repeat (6) tick();
    checks += 7;
    if (cap_rw !== 1'b0) begin errors++; $display("FAIL spiw_rw: got %b want 0", cap_rw); end
    if (cap_din !== 16'hA55A) begin errors++; $display("FAIL spiw_din: got %h want a55a", cap_din); end
    if (cap_udsn !== 1'b0 || cap_ldsn !== 1'b0) begin errors++; $display("FAIL spiw_strb: udsn=%b ldsn=%b want 0/0", cap_udsn, cap_ldsn); end
    if (cap_addr !== 23'h10) begin errors++; $display("FAIL spiw_addr: got %h want 10", cap_addr); end
    if (spi_ack_cnt - s0 !== 1) begin errors++; $display("FAIL spiw_pulse: ack cycles %0d want 1", spi_ack_cnt - s0); end
    if (dtack_low_cnt - d0 !== 0 || cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL spiw_dtack: low cycles %0d want 0", dtack_low_cnt - d0); end
    if (asn_falls - f0 !== 1) begin errors++; $display("FAIL spiw_accesses: got %0d want 1", asn_falls - f0); end
    cpu_as_n = 1'b1; cpu_sel = 1'b0; spi_excl = 1'b0;
    tick();
  endtask

  task automatic test_spi_read();
    ack_en = 1'b1; mem_rdata = 16'hBEEF;
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 23'h1234;
    wait_spi_ack("spir_wait");
    checks += 2;
    if (spi_rdata !== 16'hBEEF) begin errors++; $display("FAIL spir_data: got %h want beef", spi_rdata); end
    if (cap_rw !== 1'b1 || cap_addr !== 23'h1234) begin errors++; $display("FAIL spir_cmd: rw=%b addr=%h want 1/1234", cap_rw, cap_addr); end
    spi_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_starvation();
    int  ncpu = 0, guard = 0;
    bit  got_spi = 1'b0;
    ack_en = 1'b1;
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 23'h20; spi_wdata = 16'h0F0F;
    cpu_a = 23'h000400; cpu_rw = 1'b1; cpu_sel = 1'b1; cpu_as_n = 1'b0;
    while (!got_spi && guard < 3000) begin
      tick(); guard++;
      if (spi_ack === 1'b1) begin
        got_spi = 1'b1; spi_req = 1'b0;
      end else if (cpu_dtack_n === 1'b0) begin
        ncpu++; cpu_as_n = 1'b1; tick(); cpu_as_n = 1'b0;
      end
    end
    checks += 2;
    if (!got_spi) begin errors++; $display("FAIL starve_spi: spi never granted, got 0 want 1"); end
    if (ncpu !== 8) begin errors++; $display("FAIL starve_cnt_grants: cpu grants before spi %0d want 8", ncpu); end
    wait_dtack("starve_tail");
    cpu_as_n = 1'b1;
    tick();
    checks++;
    if (dut.u_prio.starve_cnt_q !== 4'd0) begin errors++; $display("FAIL starve_clear: got %0d want 0", dut.u_prio.starve_cnt_q); end
    cpu_sel = 1'b0;
    tick();
  endtask

  task automatic test_byte_write();
    int f0 = asn_falls;
    ack_en = 1'b1;
    cpu_a = 23'h002000; cpu_rw = 1'b0; cpu_dout = 16'h12AB;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b1; cpu_sel = 1'b1; cpu_as_n = 1'b0;
    wait_dtack("bw_wait");
    repeat (10) tick();
    checks += 5;
    if (cap_udsn !== 1'b0 || cap_ldsn !== 1'b1) begin errors++; $display("FAIL bw_strb: udsn=%b ldsn=%b want 0/1", cap_udsn, cap_ldsn); end
    if (cap_rw !== 1'b0 || cap_din !== 16'h12AB) begin errors++; $display("FAIL bw_cmd: rw=%b din=%h want 0/12ab", cap_rw, cap_din); end
    if (asn_falls - f0 !== 1) begin errors++; $display("FAIL bw_once: accesses %0d want 1", asn_falls - f0); end
    if (cpu_dtack_n !== 1'b0 || mem_if.mem_asn !== 1'b1) begin errors++; $display("FAIL bw_hold: dtack_n=%b asn=%b want 0/1", cpu_dtack_n, mem_if.mem_asn); end
    cpu_as_n = 1'b1;
    tick();
    if (cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL bw_release: dtack_n=%b want 1", cpu_dtack_n); end
    cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_spi();
    int s0, n = 0;
    ack_en = 1'b0;
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 23'h55;
    while (mem_if.mem_asn !== 1'b0 && n < 50) begin tick(); n++; end
    checks++;
    if (dut.state_q !== ST_SPI_ACC) begin errors++; $display("FAIL rm_enter: state=%0d want %0d", dut.state_q, ST_SPI_ACC); end
    reset_n = 1'b0; spi_req = 1'b0;
    tick();
    reset_n = 1'b1;
    s0 = spi_ack_cnt;
    checks += 2;
    if (mem_if.mem_asn !== 1'b1 || mem_if.mem_udsn !== 1'b1 || mem_if.mem_ldsn !== 1'b1 || mem_if.mem_rw !== 1'b1)
      begin errors++; $display("FAIL rm_strb: asn=%b udsn=%b ldsn=%b rw=%b want 1111", mem_if.mem_asn, mem_if.mem_udsn, mem_if.mem_ldsn, mem_if.mem_rw); end
    if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rm_state: got %0d want 0", dut.state_q); end
    tick();
    mem_rdata = 16'h7777; inject_ack = 1'b1;
    tick();
    inject_ack = 1'b0;
    tick(); tick();
    checks += 3;
    if (spi_ack_cnt - s0 !== 0) begin errors++; $display("FAIL rm_late_ack: spi_ack cycles %0d want 0", spi_ack_cnt - s0); end
    if (spi_rdata !== 16'h0000) begin errors++; $display("FAIL rm_rdata: got %h want 0000", spi_rdata); end
    if (dut.state_q !== ST_IDLE || mem_if.mem_asn !== 1'b1) begin errors++; $display("FAIL rm_idle: state=%0d asn=%b want 0/1", dut.state_q, mem_if.mem_asn); end
    ack_en = 1'b1;
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0, d0 = dtack_low_cnt;
    ack_en = 1'b0;
    cpu_a = 23'h000900; cpu_rw = 1'b1; cpu_sel = 1'b1; cpu_as_n = 1'b0;
    while (mem_if.mem_asn !== 1'b0 && n < 50) begin tick(); n++; end
    n = 0;
    while (cpu_berr_n !== 1'b0 && n < 600) begin tick(); n++; end
    checks += 3;
    if (n !== 255) begin errors++; $display("FAIL tmo_lat: berr after %0d cycles want 255", n); end
    if (dtack_low_cnt - d0 !== 0) begin errors++; $display("FAIL tmo_dtack: low cycles %0d want 0", dtack_low_cnt - d0); end
    if (mem_if.mem_asn !== 1'b1) begin errors++; $display("FAIL tmo_asn: got %b want 1", mem_if.mem_asn); end
    cpu_as_n = 1'b1;
    tick();
    checks++;
    if (cpu_berr_n !== 1'b1 || dut.state_q !== ST_IDLE) begin errors++; $display("FAIL tmo_end: berr_n=%b state=%0d want 1/0", cpu_berr_n, dut.state_q); end
    cpu_sel = 1'b0; ack_en = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
    test_spi_write_excl();
    test_spi_read();
    test_starvation();
    test_byte_write();
    test_reset_mid_spi();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
